// File: rtl/mul_div_unit_pkg.sv
// mul_div_unit_pkg: operation and FSM state encodings shared by the multiply/divide unit
package mul_div_unit_pkg;
  typedef enum logic [3:0] {
    MDU_NOP = 4'd0, MDU_MULT, MDU_MULTU, MDU_MADD, MDU_MADDU,
    MDU_MSUB, MDU_MSUBU, MDU_DIV, MDU_DIVU
  } mdu_op_e;
  typedef enum logic [2:0] {ST_IDLE, ST_MUL, ST_DIV, ST_FIX, ST_DONE} mdu_state_e;
  function automatic logic op_known(input logic [3:0] op);
    return op inside {MDU_MULT, MDU_MULTU, MDU_MADD, MDU_MADDU, MDU_MSUB, MDU_MSUBU, MDU_DIV, MDU_DIVU};
  endfunction
  function automatic logic op_signed(input logic [3:0] op);
    return op inside {MDU_MULT, MDU_MADD, MDU_MSUB, MDU_DIV};
  endfunction
  function automatic logic op_div(input logic [3:0] op);
    return op inside {MDU_DIV, MDU_DIVU};
  endfunction
  function automatic logic op_acc(input logic [3:0] op);
    return op inside {MDU_MADD, MDU_MADDU, MDU_MSUB, MDU_MSUBU};
  endfunction
  function automatic logic op_sub(input logic [3:0] op);
    return op inside {MDU_MSUB, MDU_MSUBU};
  endfunction
endpackage

// File: rtl/mul_div_unit_div.sv
// mdu_div: radix-2 restoring divider core, one quotient bit per cycle on operand magnitudes
module mdu_div #(
  parameter int DW = 32
) (
  input  logic          aclk,
  input  logic          aresetn,
  input  logic          i_start,
  input  logic          i_signed,
  input  logic          i_abort,
  input  logic [DW-1:0] i_dividend,
  input  logic [DW-1:0] i_divisor,
  output logic [DW-1:0] o_quotient,
  output logic [DW-1:0] o_remainder,
  output logic          o_done
);
  localparam int CW = $clog2(DW);
  logic [DW-1:0] r_q, r_rem, r_d;
  logic [CW-1:0] r_cnt;
  logic          r_run, r_negq, r_negr;
  logic [DW:0]   w_sh, w_diff;
  assign w_sh   = {r_rem, r_q[DW-1]};
  assign w_diff = w_sh - {1'b0, r_d};
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_q    <= '0;
      r_rem  <= '0;
      r_d    <= '0;
      r_cnt  <= '0;
      r_run  <= 1'b0;
      r_negq <= 1'b0;
      r_negr <= 1'b0;
    end else if (i_start) begin
      r_q    <= (i_signed & i_dividend[DW-1]) ? -i_dividend : i_dividend;
      r_d    <= (i_signed & i_divisor[DW-1]) ? -i_divisor : i_divisor;
      r_rem  <= '0;
      r_cnt  <= CW'(DW - 1);
      r_run  <= 1'b1;
      r_negq <= i_signed & (i_dividend[DW-1] ^ i_divisor[DW-1]);
      r_negr <= i_signed & i_dividend[DW-1];
    end else if (i_abort) begin
      r_run <= 1'b0;
    end else if (r_run) begin
      r_rem <= w_diff[DW] ? w_sh[DW-1:0] : w_diff[DW-1:0];
      r_q   <= {r_q[DW-2:0], ~w_diff[DW]};
      r_cnt <= r_cnt - 1'b1;
      r_run <= r_cnt != '0;
    end
  end
  // done marks the final iteration; magnitudes are settled from the next cycle on
  assign o_done      = r_run & (r_cnt == '0);
  assign o_quotient  = r_negq ? -r_q : r_q;
  assign o_remainder = r_negr ? -r_rem : r_rem;
endmodule

// File: rtl/mul_div_unit.sv
// mul_div_unit: pipelined multiply/multiply-accumulate and iterative divide for HI/LO results
module mul_div_unit
  import mul_div_unit_pkg::*;
#(
  parameter int DW         = 32,
  parameter int MUL_STAGES = 2
) (
  input  logic          aclk,
  input  logic          aresetn,
  input  logic [3:0]    op,
  input  logic          valid,
  output logic          ready,
  input  logic [DW-1:0] opr1,
  input  logic [DW-1:0] opr2,
  input  logic [DW-1:0] hi_i,
  input  logic [DW-1:0] lo_i,
  input  logic          flush,
  output logic          res_valid,
  output logic [DW-1:0] res_hi,
  output logic [DW-1:0] res_lo,
  output logic          busy
);
  localparam int H  = DW / 2;
  localparam int PS = (MUL_STAGES > 1) ? MUL_STAGES - 1 : 1;
  typedef struct packed {
    logic [DW-1:0]   ll, lh, hl, hh;
    logic            neg, acc_en, sub;
    logic [2*DW-1:0] acc;
  } ms_t;
  mdu_state_e      r_state, w_next;
  logic [1:0]      r_mcnt;
  ms_t             r_ms [PS];
  ms_t             w_ms_in, w_ms;
  logic            w_accept, w_sgn, w_div0, w_div_done;
  logic [DW-1:0]   w_a, w_b, w_quot, w_rem;
  logic [2*DW-1:0] w_prod, w_sprod, w_mul_res, w_res_nxt, r_res;
  assign w_accept = valid & ready & ~flush & op_known(op);
  assign w_sgn    = op_signed(op);
  assign w_div0   = opr2 == '0;
  assign w_a      = (w_sgn & opr1[DW-1]) ? -opr1 : opr1;
  assign w_b      = (w_sgn & opr2[DW-1]) ? -opr2 : opr2;
  always_comb begin
    w_ms_in.ll     = DW'(w_a[H-1:0]) * DW'(w_b[H-1:0]);
    w_ms_in.lh     = DW'(w_a[H-1:0]) * DW'(w_b[DW-1:H]);
    w_ms_in.hl     = DW'(w_a[DW-1:H]) * DW'(w_b[H-1:0]);
    w_ms_in.hh     = DW'(w_a[DW-1:H]) * DW'(w_b[DW-1:H]);
    w_ms_in.neg    = w_sgn & (opr1[DW-1] ^ opr2[DW-1]);
    w_ms_in.acc_en = op_acc(op);
    w_ms_in.sub    = op_sub(op);
    w_ms_in.acc    = {hi_i, lo_i};
  end
  // partial products ride MUL_STAGES-1 registers; the result register is the last stage
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      for (int i = 0; i < PS; i++) r_ms[i] <= '0;
    end else begin
      if (w_accept) r_ms[0] <= w_ms_in;
      for (int i = 1; i < PS; i++) r_ms[i] <= r_ms[i-1];
    end
  end
  assign w_ms      = (MUL_STAGES == 1) ? w_ms_in : r_ms[PS-1];
  assign w_prod    = {w_ms.hh, w_ms.ll} + {{H{1'b0}}, w_ms.lh, {H{1'b0}}} + {{H{1'b0}}, w_ms.hl, {H{1'b0}}};
  assign w_sprod   = w_ms.neg ? -w_prod : w_prod;
  assign w_mul_res = !w_ms.acc_en ? w_sprod : w_ms.sub ? w_ms.acc - w_sprod : w_ms.acc + w_sprod;
  mdu_div #(.DW(DW)) u_div (
    .aclk        (aclk),
    .aresetn     (aresetn),
    .i_start     (w_accept & op_div(op) & ~w_div0),
    .i_signed    (w_sgn),
    .i_abort     (flush),
    .i_dividend  (opr1),
    .i_divisor   (opr2),
    .o_quotient  (w_quot),
    .o_remainder (w_rem),
    .o_done      (w_div_done)
  );
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) r_state <= ST_IDLE;
    else r_state <= w_next;
  end
  always_comb begin
    w_next = ST_IDLE;
    unique case (r_state)
      ST_IDLE: w_next = !w_accept ? ST_IDLE : op_div(op) ? (w_div0 ? ST_DONE : ST_DIV) :
                        (MUL_STAGES == 1) ? ST_DONE : ST_MUL;
      ST_MUL:  w_next = flush ? ST_IDLE : (r_mcnt == 2'(MUL_STAGES - 2)) ? ST_DONE : ST_MUL;
      ST_DIV:  w_next = flush ? ST_IDLE : w_div_done ? ST_FIX : ST_DIV;
      ST_FIX:  w_next = flush ? ST_IDLE : ST_DONE;
      default: w_next = ST_IDLE;
    endcase
  end
  always_comb begin
    ready     = r_state == ST_IDLE;
    busy      = r_state != ST_IDLE && r_state != ST_DONE;
    res_valid = r_state == ST_DONE && !flush;
  end
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) r_mcnt <= '0;
    else r_mcnt <= (r_state == ST_MUL) ? r_mcnt + 1'b1 : '0;
  end
  // divide-by-zero resolves at accept; otherwise the result lands on entry to DONE
  assign w_res_nxt = (r_state == ST_FIX) ? {w_rem, w_quot} :
                     (r_state == ST_IDLE && op_div(op)) ? {opr1, {DW{1'b1}}} : w_mul_res;
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) r_res <= '0;
    else if (w_next == ST_DONE) r_res <= w_res_nxt;
  end
  assign {res_hi, res_lo} = r_res;
endmodule

// File: tb/tb_mul_div_unit.sv
// tb_mul_div_unit: randomized and directed checks of mul_div_unit against an arithmetic reference model
module tb_mul_div_unit;
  import mul_div_unit_pkg::*;
  localparam int DW = 32;
  localparam int MS = 2;
  logic          aclk = 1'b0, aresetn = 1'b1, valid = 1'b0, flush = 1'b0;
  logic [3:0]    op = '0;
  logic [DW-1:0] opr1 = '0, opr2 = '0, hi_i = '0, lo_i = '0;
  logic          ready, res_valid, busy;
  logic [DW-1:0] res_hi, res_lo;
  int            n_tests = 0, n_fail = 0;
  int            lat;
  mdu_op_e       ops [8] = '{MDU_MULT, MDU_MULTU, MDU_MADD, MDU_MADDU, MDU_MSUB, MDU_MSUBU, MDU_DIV, MDU_DIVU};
  always #5 aclk = ~aclk;
  mul_div_unit #(.DW(DW), .MUL_STAGES(MS)) dut (
    .aclk      (aclk),
    .aresetn   (aresetn),
    .op        (op),
    .valid     (valid),
    .ready     (ready),
    .opr1      (opr1),
    .opr2      (opr2),
    .hi_i      (hi_i),
    .lo_i      (lo_i),
    .flush     (flush),
    .res_valid (res_valid),
    .res_hi    (res_hi),
    .res_lo    (res_lo),
    .busy      (busy)
  );
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask
  function automatic logic [63:0] model(input logic [3:0] o, input logic [31:0] a, b, h, l);
    longint sa, sb, q, r;
    logic [63:0] p;
    logic sgn;
    sa  = $signed(a);
    sb  = $signed(b);
    sgn = o inside {MDU_MULT, MDU_MADD, MDU_MSUB, MDU_DIV};
    if (o == MDU_DIV || o == MDU_DIVU) begin
      if (b == 0) return {a, 32'hFFFFFFFF};
      if (!sgn) return {a % b, a / b};
      if (a == 32'h80000000 && b == 32'hFFFFFFFF) return {32'h0, 32'h80000000};
      q = sa / sb;
      r = sa % sb;
      return {r[31:0], q[31:0]};
    end
    p = sgn ? 64'(sa * sb) : {32'h0, a} * {32'h0, b};
    if (o inside {MDU_MADD, MDU_MADDU}) return {h, l} + p;
    if (o inside {MDU_MSUB, MDU_MSUBU}) return {h, l} - p;
    return p;
  endfunction
  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'h80000000;
      2: return 32'hFFFFFFFF;
      3: return 32'h1;
      default: return $urandom();
    endcase
  endfunction
  task automatic issue(input logic [3:0] o, input logic [31:0] a, b, h, l);
    op = o; opr1 = a; opr2 = b; hi_i = h; lo_i = l; valid = 1'b1;
    @(posedge aclk);
    #1 valid = 1'b0;
  endtask
  task automatic wait_res(output int n);
    n = 0;
    for (int k = 1; k <= 200; k++) begin
      @(negedge aclk);
      if (res_valid) begin
        n = k;
        check("ready_in_done", {ready, busy}, 2'b00);
        break;
      end
    end
    @(posedge aclk);
    #1 check("post_idle", {ready, busy, res_valid}, 3'b100);
  endtask
  task automatic quiet(input string tag, input int n);
    int c = 0;
    repeat (n) begin
      @(negedge aclk);
      if (res_valid) c++;
    end
    @(posedge aclk);
    #1 check(tag, c, 0);
  endtask
  task automatic run_op(input string tag, input logic [3:0] o, input logic [31:0] a, b, h, l);
    logic [63:0] e;
    int el, n;
    e  = model(o, a, b, h, l);
    el = !(o == MDU_DIV || o == MDU_DIVU) ? MS : (b == 0) ? 1 : DW + 2;
    issue(o, a, b, h, l);
    check({tag, "_busy"}, busy, 64'(el > 1));
    wait_res(n);
    check({tag, "_lat"}, n, el);
    check({tag, "_res"}, {res_hi, res_lo}, e);
  endtask
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1);
  end
  initial begin
    #3 aresetn = 1'b0;
    #1 check("rst_ctl", {ready, busy, res_valid}, 3'b100);
    check("rst_res", {res_hi, res_lo}, 64'h0);
    @(posedge aclk);
    #1 aresetn = 1'b1;
    @(posedge aclk);
    #1 check("rst_rel", {ready, busy, res_valid}, 3'b100);
    run_op("mult", MDU_MULT, 32'hFFFFFFFD, 32'h5, 0, 0);
    check("mult_const", {res_hi, res_lo}, 64'hFFFFFFFF_FFFFFFF1);
    run_op("div", MDU_DIV, 32'hFFFFFFF9, 32'h2, 0, 0);
    check("div_const", {res_hi, res_lo}, 64'hFFFFFFFF_FFFFFFFD);
    run_op("divz", MDU_DIVU, 32'h12345678, 32'h0, 0, 0);
    check("divz_const", {res_hi, res_lo}, 64'h12345678_FFFFFFFF);
    run_op("maddu", MDU_MADDU, 32'h1, 32'h1, 32'h0, 32'hFFFFFFFF);
    check("maddu_const", {res_hi, res_lo}, 64'h00000001_00000000);
    run_op("msub", MDU_MSUB, 32'h1, 32'h1, 32'h0, 32'hFFFFFFFF);
    check("msub_const", {res_hi, res_lo}, 64'h00000000_FFFFFFFE);
    run_op("divmin", MDU_DIV, 32'h80000000, 32'hFFFFFFFF, 0, 0);
    check("divmin_const", {res_hi, res_lo}, 64'h00000000_80000000);
    for (int i = 0; i < 30; i++)
      run_op("rnd", ops[$urandom_range(0, 7)], pick(), pick(), $urandom(), $urandom());
    issue(MDU_DIVU, 32'd1000, 32'd7, 0, 0);
    repeat (9) @(posedge aclk);
    #1 flush = 1'b1;
    @(posedge aclk);
    #1 flush = 1'b0;
    check("flush_idle", {ready, busy}, 2'b10);
    quiet("flush_quiet", 40);
    run_op("multu", MDU_MULTU, 32'd3, 32'd4, 0, 0);
    check("multu_const", {res_hi, res_lo}, 64'hC);
    issue(MDU_DIVU, 32'd100, 32'd7, 0, 0);
    op = MDU_MULT; opr1 = 32'd5; opr2 = 32'd5; valid = 1'b1;
    repeat (5) @(posedge aclk);
    #1 valid = 1'b0;
    wait_res(lat);
    check("busy_ign_lat", lat, DW + 2 - 5);
    check("busy_ign_res", {res_hi, res_lo}, model(MDU_DIVU, 32'd100, 32'd7, 0, 0));
    quiet("busy_ign_quiet", 10);
    op = MDU_NOP; valid = 1'b1;
    @(posedge aclk);
    #1 valid = 1'b0;
    check("nop_idle", {ready, busy}, 2'b10);
    quiet("nop_quiet", 5);
    op = 4'hC; valid = 1'b1;
    @(posedge aclk);
    #1 valid = 1'b0;
    check("undef_idle", {ready, busy}, 2'b10);
    quiet("undef_quiet", 5);
    op = MDU_MULT; opr1 = 32'd2; opr2 = 32'd2; valid = 1'b1; flush = 1'b1;
    @(posedge aclk);
    #1 valid = 1'b0; flush = 1'b0;
    check("flushv_idle", {ready, busy}, 2'b10);
    quiet("flushv_quiet", 5);
    issue(MDU_MULT, 32'd7, 32'd9, 0, 0);
    @(posedge aclk);
    #1 flush = 1'b1;
    @(negedge aclk);
    check("flush_done_rv", {ready, busy, res_valid}, 3'b000);
    @(posedge aclk);
    #1 flush = 1'b0;
    check("flush_done_idle", {ready, busy, res_valid}, 3'b100);
    quiet("flush_done_quiet", 5);
    issue(MDU_DIV, 32'd12345, 32'd17, 0, 0);
    repeat (5) @(posedge aclk);
    #1 aresetn = 1'b0;
    #1 check("arst_ctl", {ready, busy, res_valid}, 3'b100);
    check("arst_res", {res_hi, res_lo}, 64'h0);
    @(posedge aclk);
    #1 aresetn = 1'b1;
    quiet("arst_quiet", 50);
    run_op("after_rst", MDU_MADD, 32'hFFFFFFFF, 32'd6, 32'd0, 32'd10);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/mul_div_unit.md
MUL_DIV_UNIT -- requirements
Module: mul_div_unit

Interface
REQ-001 Parameter DW, default 32, operand/HI/LO width, legal 8..64, even.
REQ-002 Parameter MUL_STAGES, default 2, multiplier latency in cycles, legal 1..4.
REQ-003 aclk  in  1  sole clock, all state on rising edge.
REQ-004 aresetn  in  1  reset, asynchronous assert, active-low.
REQ-005 op  in  4  operation: NOP, MULT, MULTU, MADD, MADDU, MSUB, MSUBU, DIV, DIVU.
REQ-006 valid  in  1  request, qualifies op/opr1/opr2/hi_i/lo_i.
REQ-007 ready  out  1  unit idle, request accepted this cycle if valid.
REQ-008 opr1, opr2  in  DW each  rs/rt operands (dividend/divisor for DIV*).
REQ-009 hi_i, lo_i  in  DW each  current architectural HI/LO, used by MADD*/MSUB*.
REQ-010 flush  in  1  pipeline cancel (exception/ERET).
REQ-011 res_valid  out  1  one-cycle result strobe.
REQ-012 res_hi, res_lo  out  DW each  result, meaningful only with res_valid.
REQ-013 busy  out  1  operation in flight; drives EX stall request.

Function
REQ-014 Accept = valid & ready & ~flush & op!=NOP; NOP or undefined op not accepted, no result.
REQ-015 ready SHALL equal (state==IDLE); requests while busy ignored, operands captured only at accept.
REQ-016 FSM states IDLE, MUL, DIV, FIX, DONE; IDLE->MUL (MULT*/MADD*/MSUB*), IDLE->DIV (DIV*, divisor!=0), IDLE->DONE (DIV* divisor==0).
REQ-017 Multiply: signed ops use |opr1|*|opr2| with sign fix s1^s2, unsigned use raw operands; 2DW-bit product.
REQ-018 MUL stage counts MUL_STAGES cycles; res_valid asserted exactly MUL_STAGES cycles after accept cycle.
REQ-019 MADD*: {res_hi,res_lo} = {hi_i,lo_i} + product; MSUB*: {hi_i,lo_i} - product; modulo 2^(2DW), hi_i/lo_i sampled at accept.
REQ-020 Divide: radix-2 restoring, one quotient bit per cycle, DW cycles in DIV, then 1 cycle FIX for sign correction, then DONE.
REQ-021 Divide latency: res_valid exactly DW+2 cycles after accept (34 for DW=32).
REQ-022 Signed divide: quotient sign s1^s2, remainder sign s1; res_lo=quotient, res_hi=remainder.
REQ-023 Signed MIN / -1: res_lo=MIN, res_hi=0, normal latency, no exception.
REQ-024 Divide by zero: res_lo=all ones, res_hi=opr1, res_valid 1 cycle after accept.
REQ-025 DONE lasts one cycle with res_valid=1, then IDLE; ready high in the cycle after res_valid.
REQ-026 busy = (state!=IDLE & state!=DONE).
REQ-027 flush in any state: next state IDLE, no res_valid for the cancelled op; flush in DONE suppresses res_valid that cycle.
REQ-028 flush and valid in same cycle: flush wins, nothing accepted.
REQ-029 res_hi/res_lo hold last result outside res_valid; no HI/LO register in this unit.

Reset
REQ-030 aresetn low: state=IDLE, ready=1 after reset releases, res_valid=0, busy=0, res_hi=res_lo=0, counters/partial remainder=0.
REQ-031 Reset asserted mid-operation aborts immediately, no result ever delivered for that op.

Structure
REQ-032 Op encodings MDU_* and FSM state encodings in the shared defines header; DW/MUL_STAGES as module parameters.
REQ-033 One sub-module mdu_div: iterative divider core (start, signed, operands in; quotient, remainder, done out).
REQ-034 Multiplier: DW/2-bit partial products (4 products) summed over MUL_STAGES pipeline registers.

Verification
REQ-035 MULT opr1=FFFFFFFD, opr2=00000005 -> after 2 cycles res_hi=FFFFFFFF, res_lo=FFFFFFF1.
REQ-036 DIV opr1=FFFFFFF9, opr2=00000002 -> after 34 cycles res_lo=FFFFFFFD, res_hi=FFFFFFFF.
REQ-037 DIVU opr1=12345678, opr2=0 -> next cycle res_lo=FFFFFFFF, res_hi=12345678.
REQ-038 MADDU hi_i=0, lo_i=FFFFFFFF, opr1=opr2=1 -> res_hi=00000001, res_lo=00000000; MSUB same inputs -> res_hi=0, res_lo=FFFFFFFE.
REQ-039 DIV 80000000/FFFFFFFF -> res_lo=80000000, res_hi=0 after 34 cycles.
REQ-040 Flush at cycle 10 of DIVU -> no res_valid, ready=1 next cycle; new MULTU 3*4 then yields lo=0000000C after 2 cycles.
